// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared definitions for the data-memory bus controller and the load unit:
// RISC-V load/store width codes, FSM state encoding and access-size helpers.
package dmem_bus_ctrl_pkg;

    // funct3 width codes
    localparam logic [2:0] Funct3Byte  = 3'b000;
    localparam logic [2:0] Funct3Half  = 3'b001;
    localparam logic [2:0] Funct3Word  = 3'b010;
    localparam logic [2:0] Funct3ByteU = 3'b100;
    localparam logic [2:0] Funct3HalfU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10
    } size_e;

    // Width depends only on funct3[1:0]; the unsigned variants share it.
    function automatic size_e access_size(input logic [2:0] funct3);
        size_e size;
        case (funct3[1:0])
            2'b00:   size = SizeByte;
            2'b01:   size = SizeHalf;
            default: size = SizeWord;
        endcase
        return size;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (access_size(funct3))
            SizeByte: mis = 1'b0;
            SizeHalf: mis = off[0];
            default:  mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Data-memory bus: word-addressed, byte-lane enables, ack/err termination.
interface dmem_bus_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output addr, wdata, sel, we, cyc, stb,
        input  rdata, ack, err
    );

    modport slave (
        input  addr, wdata, sel, we, cyc, stb,
        output rdata, ack, err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte-enable generation and store-data
// replication on the write side, right-justification of read data.
module dmem_lane_align
    import dmem_bus_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_shift
);

    // Select lanes and replicate the store data across them.
    always_comb begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        case (access_size(funct3))
            SizeByte: begin
                sel       = 4'b0001 << wr_off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SizeHalf: begin
                sel       = 4'b0011 << wr_off;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                sel       = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Move the addressed byte/half down to bit 0; extension is left to the load unit.
    always_comb begin
        rdata_shift = rdata >> {rd_off, 3'b000};
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: accepts one load/store from the execute stage,
// runs a single bus cycle with timeout, and reports completion/errors.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [2:0]            funct3_i,
    dmem_bus_ctrl_if.master       dmem,
    output logic [31:0]           data_mem_o,
    output logic [2:0]            funct3_o,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o
);

    // Value of the wait counter in the last BUSY cycle allowed before abort.
    localparam logic [7:0] LastWait = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [31:0] data_mem_q;
    logic        mis_q;
    logic        berr_q;

    logic        accept;
    logic        req_mis;
    logic        timeout;
    logic [3:0]  sel_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_shift;

    assign accept  = (state_q == StIdle) && req_valid_i;
    assign req_mis = is_misaligned(funct3_i, req_addr_i[1:0]);
    assign timeout = (cnt_q == LastWait);

    dmem_lane_align u_lane_align (
        .funct3      (funct3_i),
        .wr_off      (req_addr_i[1:0]),
        .wdata       (req_wdata_i),
        .sel         (sel_new),
        .wdata_rep   (wdata_new),
        .rd_off      (off_q),
        .rdata       (dmem.rdata),
        .rdata_shift (rdata_shift)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; misaligned requests skip the bus and go straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = req_mis ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (dmem.err || dmem.ack || timeout) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture, wait counter and completion status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            off_q      <= '0;
            funct3_q   <= '0;
            data_mem_q <= '0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q <= funct3_i;
                off_q    <= req_addr_i[1:0];
                mis_q    <= req_mis;
                berr_q   <= 1'b0;
                cnt_q    <= '0;
                if (!req_mis) begin
                    addr_q  <= {req_addr_i[31:2], 2'b00};
                    wdata_q <= wdata_new;
                    sel_q   <= sel_new;
                    we_q    <= req_we_i;
                end
            end
            if (state_q == StBusy) begin
                // err beats ack; a real ack in the final wait cycle beats the timeout
                if (dmem.err) begin
                    berr_q     <= 1'b1;
                    data_mem_q <= '0;
                end else if (dmem.ack) begin
                    if (!we_q) begin
                        data_mem_q <= rdata_shift;
                    end
                end else if (timeout) begin
                    berr_q     <= 1'b1;
                    data_mem_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    // Bus drive and pipeline-facing outputs.
    always_comb begin
        dmem.addr    = addr_q;
        dmem.wdata   = wdata_q;
        dmem.sel     = sel_q;
        dmem.we      = we_q;
        dmem.cyc     = (state_q == StBusy);
        dmem.stb     = (state_q == StBusy);
        data_mem_o   = data_mem_q;
        funct3_o     = funct3_q;
        stall_o      = ((state_q == StIdle) && req_valid_i) || (state_q == StBusy);
        done_o       = (state_q == StDone);
        misaligned_o = (state_q == StDone) && mis_q;
        bus_err_o    = (state_q == StDone) && berr_q;
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed vector table, randomized
// accesses against a behavioural model, timeout and reset-abort sequences.
module tb_dmem_bus_ctrl;

    localparam int Timeout = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  funct3;
    logic [31:0] data_mem;
    logic [2:0]  funct3_out;
    logic        stall;
    logic        done;
    logic        misaligned;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_bus_ctrl_if bus ();

    dmem_bus_ctrl #(.TIMEOUT_CYCLES(Timeout)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .funct3_i     (funct3),
        .dmem         (bus),
        .data_mem_o   (data_mem),
        .funct3_o     (funct3_out),
        .stall_o      (stall),
        .done_o       (done),
        .misaligned_o (misaligned),
        .bus_err_o    (bus_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] data_mem;
        logic [2:0]  funct3;
        logic        mis;
        logic        berr;
        int          lat;
        int          stall_cnt;
        int          busy;
        logic        unstable;
        logic        got_done;
        logic        stall_in_done;
        logic        done_after;
    } obs_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] data_mem;
        logic        mis;
        logic        berr;
        int          lat;
    } exp_t;

    // resp: 0 ack, 1 err, 2 ack+err, 3 never answer
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          waits;
        int          resp;
        logic [3:0]  x_sel;
        logic [31:0] x_wdata;
        logic [31:0] x_dm;
        logic        x_mis;
        logic        x_berr;
        int          x_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: byte-granular view of the access.
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] f3,
                                   input logic [31:0] rdata, input int waits,
                                   input int resp, input logic [31:0] prev_dm);
        exp_t e;
        int   size;
        int   off;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(addr % 32'd4);
        e.mis  = (off % size) != 0;
        e.addr = addr - 32'(off);
        e.sel  = 4'(((1 << size) - 1) << off);
        e.we   = we;
        for (int i = 0; i < 4; i++) begin
            e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
        end
        e.berr = 1'b0;
        if (e.mis) begin
            e.data_mem = prev_dm;
            e.lat      = 1;
        end else if (resp != 0) begin
            e.data_mem = 32'h0;
            e.berr     = 1'b1;
            e.lat      = (resp == 3) ? Timeout + 1 : waits + 2;
        end else begin
            e.data_mem = we ? prev_dm : (rdata >> (8 * off));
            e.lat      = waits + 2;
        end
        return e;
    endfunction

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3, input logic [31:0] rdata, input int waits,
                             input int resp, input bit hold, output obs_t o);
        o = '0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        funct3    = f3;
        #1;
        o.stall_cnt = int'(stall);
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
        end else begin
            // ignored request with scrambled fields must not disturb the bus
            req_we    = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            funct3    = 3'($urandom);
        end
        for (int c = 1; c <= 400; c++) begin
            #1;
            if (bus.cyc) begin
                if (o.busy == 0) begin
                    o.addr  = bus.addr;
                    o.wdata = bus.wdata;
                    o.sel   = bus.sel;
                    o.we    = bus.we;
                end else if (bus.addr !== o.addr || bus.wdata !== o.wdata ||
                             bus.sel !== o.sel || bus.we !== o.we) begin
                    o.unstable = 1'b1;
                end
                if (bus.stb !== 1'b1) o.unstable = 1'b1;
                o.busy++;
                o.stall_cnt += int'(stall);
                if (resp != 3 && o.busy - 1 == waits) begin
                    bus.rdata = rdata;
                    bus.ack   = (resp != 1);
                    bus.err   = (resp != 0);
                end
            end
            if (done) begin
                o.got_done      = 1'b1;
                o.lat           = c;
                o.data_mem      = data_mem;
                o.funct3        = funct3_out;
                o.mis           = misaligned;
                o.berr          = bus_err;
                o.stall_in_done = stall;
                req_valid       = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.ack   = 1'b0;
            bus.err   = 1'b0;
            bus.rdata = $urandom;
            if (o.got_done) break;
        end
        #1;
        o.done_after = done;
    endtask

    task automatic check_access(input string tag, input obs_t o, input exp_t e,
                                input logic [2:0] f3);
        chk({tag, " done"}, 32'(o.got_done), 32'd1);
        chk({tag, " latency"}, o.lat, e.lat);
        chk({tag, " data_mem"}, o.data_mem, e.data_mem);
        chk({tag, " misaligned"}, 32'(o.mis), 32'(e.mis));
        chk({tag, " bus_err"}, 32'(o.berr), 32'(e.berr));
        chk({tag, " funct3_o"}, 32'(o.funct3), 32'(f3));
        chk({tag, " stall cycles"}, o.stall_cnt, e.lat);
        chk({tag, " stall in done"}, 32'(o.stall_in_done), 32'd0);
        chk({tag, " done width"}, 32'(o.done_after), 32'd0);
        if (e.mis) begin
            chk({tag, " no bus cycle"}, o.busy, 0);
        end else begin
            chk({tag, " busy cycles"}, o.busy, e.lat - 1);
            chk({tag, " bus addr"}, o.addr, e.addr);
            chk({tag, " bus sel"}, 32'(o.sel), 32'(e.sel));
            chk({tag, " bus wdata"}, o.wdata, e.wdata);
            chk({tag, " bus we"}, 32'(o.we), 32'(e.we));
            chk({tag, " bus stable"}, 32'(o.unstable), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " cyc"}, 32'(bus.cyc), 32'd0);
        chk({tag, " stb"}, 32'(bus.stb), 32'd0);
        chk({tag, " we"}, 32'(bus.we), 32'd0);
        chk({tag, " sel"}, 32'(bus.sel), 32'd0);
        chk({tag, " addr"}, bus.addr, 32'd0);
        chk({tag, " wdata"}, bus.wdata, 32'd0);
        chk({tag, " data_mem"}, data_mem, 32'd0);
        chk({tag, " funct3_o"}, 32'(funct3_out), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        chk({tag, " misaligned"}, 32'(misaligned), 32'd0);
        chk({tag, " bus_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[10];
        obs_t        o;
        exp_t        e;
        logic [31:0] model_dm;
        logic [2:0]  f3_list[5];
        int          hits;

        vecs[0] = '{1'b0, 32'h100, 32'h0,        3'b010, 32'hDEADBEEF, 2, 0,
                    4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 4};
        vecs[1] = '{1'b1, 32'h203, 32'hAB,       3'b000, 32'h0,        0, 0,
                    4'h8, 32'hABABABAB, 32'hDEADBEEF, 1'b0, 1'b0, 2};
        vecs[2] = '{1'b0, 32'h202, 32'h0,        3'b101, 32'h12345678, 1, 0,
                    4'hC, 32'h0,        32'h00001234, 1'b0, 1'b0, 3};
        vecs[3] = '{1'b0, 32'h101, 32'h0,        3'b010, 32'h0,        0, 0,
                    4'h0, 32'h0,        32'h00001234, 1'b1, 1'b0, 1};
        vecs[4] = '{1'b0, 32'h104, 32'h0,        3'b010, 32'h55555555, 0, 2,
                    4'hF, 32'h0,        32'h0,        1'b0, 1'b1, 2};
        vecs[5] = '{1'b1, 32'h106, 32'h1234CAFE, 3'b001, 32'h0,        3, 0,
                    4'hC, 32'hCAFECAFE, 32'h0,        1'b0, 1'b0, 5};
        vecs[6] = '{1'b0, 32'h005, 32'h0,        3'b000, 32'h11223344, 0, 0,
                    4'h2, 32'h0,        32'h00112233, 1'b0, 1'b0, 2};
        vecs[7] = '{1'b0, 32'h003, 32'h0,        3'b001, 32'h0,        0, 0,
                    4'h0, 32'h0,        32'h00112233, 1'b1, 1'b0, 1};
        vecs[8] = '{1'b0, 32'h007, 32'h0,        3'b100, 32'hA0B0C0D0, 0, 0,
                    4'h8, 32'h0,        32'h000000A0, 1'b0, 1'b0, 2};
        vecs[9] = '{1'b0, 32'h020, 32'h0,        3'b010, 32'h0,        1, 1,
                    4'hF, 32'h0,        32'h0,        1'b0, 1'b1, 3};

        f3_list[0] = 3'b000;
        f3_list[1] = 3'b001;
        f3_list[2] = 3'b010;
        f3_list[3] = 3'b100;
        f3_list[4] = 3'b101;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        funct3    = '0;
        bus.rdata = '0;
        bus.ack   = 1'b0;
        bus.err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("reset");

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].rdata,
                      vecs[i].waits, vecs[i].resp, 1'b0, o);
            e.addr     = {vecs[i].addr[31:2], 2'b00};
            e.wdata    = vecs[i].x_wdata;
            e.sel      = vecs[i].x_sel;
            e.we       = vecs[i].we;
            e.data_mem = vecs[i].x_dm;
            e.mis      = vecs[i].x_mis;
            e.berr     = vecs[i].x_berr;
            e.lat      = vecs[i].x_lat;
            check_access($sformatf("vec%0d", i), o, e, vecs[i].f3);
        end
        model_dm = vecs[9].x_dm;

        // No response at all: abort after the full wait budget
        do_access(1'b0, 32'h40, 32'h0, 3'b010, 32'h0, 0, 3, 1'b0, o);
        e = model(1'b0, 32'h40, 32'h0, 3'b010, 32'h0, 0, 3, model_dm);
        check_access("timeout", o, e, 3'b010);
        model_dm = e.data_mem;

        // Randomized accesses against the model
        for (int i = 0; i < 60; i++) begin
            logic        r_we;
            logic [31:0] r_addr, r_wdata, r_rdata;
            logic [2:0]  r_f3;
            int          r_waits, r_sel, r_resp;
            bit          r_hold;
            r_we    = 1'($urandom);
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_f3    = f3_list[$urandom_range(0, 4)];
            r_waits = $urandom_range(0, 4);
            r_sel   = $urandom_range(0, 9);
            r_resp  = (r_sel == 7) ? 1 : (r_sel == 8) ? 2 : 0;
            r_hold  = 1'($urandom);
            do_access(r_we, r_addr, r_wdata, r_f3, r_rdata, r_waits, r_resp, r_hold, o);
            e = model(r_we, r_addr, r_wdata, r_f3, r_rdata, r_waits, r_resp, model_dm);
            check_access($sformatf("rand%0d", i), o, e, r_f3);
            model_dm = e.data_mem;
        end

        // Leave non-zero state behind, then abort a store mid-BUSY with reset
        do_access(1'b0, 32'h10, 32'h0, 3'b010, 32'h5A5A5A5A, 0, 0, 1'b0, o);
        chk("pre-abort load data_mem", o.data_mem, 32'h5A5A5A5A);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h304;
        req_wdata = 32'h77;
        funct3    = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort cyc before reset", 32'(bus.cyc), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        bus.ack   = 1'b1;
        bus.rdata = 32'hFFFFFFFF;
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            bus.ack = 1'b0;
            #1;
            hits += int'(done) + int'(bus.cyc) + int'(bus_err);
        end
        chk("late ack ignored", hits, 0);
        chk("late ack data_mem", data_mem, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
